// File: rtl/load_align_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_align_pkg
// Purpose  : Shared types and constants for the load alignment unit:
//            FSM state encoding, access-size encodings and a helper that
//            derives the in-word byte offset width from the data width.
// Revision : 1.0 - initial release
// ============================================================================
package load_align_pkg;

    // Explicit 3-bit encoding so the state register width is fixed.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_CAP0 = 3'd2,
        ST_RD1  = 3'd3,
        ST_CAP1 = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    // Access size is 2^size bytes.
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    // Number of address bits that select a byte lane within one memory word.
    function automatic int offset_width(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage : load_align_pkg
`default_nettype wire

// File: rtl/byte_lane_extract.sv
`default_nettype none
// ============================================================================
// Module   : byte_lane_extract
// Purpose  : Combinational right-justify, mask and extend of a load result
//            taken from a pair of memory beats {beat1, beat0}.
// Ports    : beat0, beat1  - first / second memory word (beat1 = 0 if unused)
//            offset        - byte offset of the access within beat0
//            size          - access size code (2^size bytes)
//            is_unsigned   - 1: zero extend, 0: sign extend
//            data          - aligned, extended result
// Revision : 1.0 - initial release
// ============================================================================
module byte_lane_extract
    import load_align_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int OFF_W     = offset_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] beat0,
    input  logic [DATA_WIDTH-1:0] beat1,
    input  logic [OFF_W-1:0]      offset,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] data
);

    logic [2*DATA_WIDTH-1:0] w_pair;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic                    w_top_bit;
    logic                    w_fill;
    logic [31:0]             w_nbits;

    assign w_pair = {beat1, beat0};

    // Only the low DATA_WIDTH bits of the shifted pair can ever be kept.
    assign w_shifted = DATA_WIDTH'(w_pair >> {offset, 3'b000});

    // Most significant kept bit, used as the sign for extension.
    always_comb begin
        w_top_bit = 1'b0;
        unique case (size)
            SZ_BYTE: w_top_bit = w_shifted[7];
            SZ_HALF: w_top_bit = w_shifted[15];
            SZ_WORD: w_top_bit = w_shifted[31];
            default: w_top_bit = w_shifted[DATA_WIDTH-1];
        endcase
    end

    assign w_fill  = w_top_bit & ~is_unsigned;
    assign w_nbits = 32'd8 << size;

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
        assign data[gi] = (32'(gi) < w_nbits) ? w_shifted[gi] : w_fill;
    end

endmodule : byte_lane_extract
`default_nettype wire

// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_align_unit
// Purpose  : Sequential load alignment for the memory stage. Accepts a byte
//            addressed load, issues one or two word-aligned memory reads and
//            returns a right-justified, sign/zero-extended result.
// Ports    : clk, rst                    - clock, synchronous active-high reset
//            req_valid/req_ready         - request handshake
//            req_addr/req_size/req_unsigned - load address, size code, extension
//            mem_req_valid/mem_ready     - memory read handshake
//            mem_addr/mem_rdata          - word address, read data (1 cycle later)
//            resp_valid/resp_ready       - response handshake
//            resp_data/resp_err          - result, error flag
// Config   : MISALIGNED_EN - when defined, misaligned and word-crossing
//            accesses are supported (two-beat reads); otherwise they return
//            resp_err and the second-beat logic is not built.
// Revision : 1.0 - initial release
// ============================================================================
module load_align_unit
    import load_align_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  mem_req_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFF_W = offset_width(DATA_WIDTH);

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic                  r_err;
    // Cleared by reset, set one cycle later: keeps req_ready low for the
    // first cycle after reset is released.
    logic                  r_init;
    logic [DATA_WIDTH-1:0] r_beat0;
    logic [DATA_WIDTH-1:0] w_beat1;

    logic                  w_accept;
    logic                  w_size_ok;
    logic                  w_req_err;
    logic [ADDR_WIDTH-1:0] w_aligned;
    logic [OFF_W-1:0]      w_offset;
    logic [DATA_WIDTH-1:0] w_extract;

    assign w_accept  = req_valid & req_ready;
    assign w_size_ok = (req_size != SZ_DWORD) || (DATA_WIDTH == 64);
    assign w_aligned = {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign w_offset  = r_addr[OFF_W-1:0];

`ifdef MISALIGNED_EN
    logic [DATA_WIDTH-1:0] r_beat1;
    logic [4:0]            w_end;
    logic                  w_cross;

    assign w_beat1   = r_beat1;
    assign w_req_err = ~w_size_ok;
    // The access crosses into the next word when its last byte lies past
    // the end of the first word.
    assign w_end     = 5'(w_offset) + (5'd1 << r_size);
    assign w_cross   = w_end > 5'(LANES);
`else
    logic w_misaligned;

    assign w_beat1 = '0;

    always_comb begin
        w_misaligned = 1'b0;
        unique case (req_size)
            SZ_BYTE: w_misaligned = 1'b0;
            SZ_HALF: w_misaligned = req_addr[0];
            SZ_WORD: w_misaligned = |req_addr[1:0];
            default: w_misaligned = |req_addr[2:0];
        endcase
    end

    assign w_req_err = ~w_size_ok | w_misaligned;
`endif

    byte_lane_extract #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_extract (
        .beat0       (r_beat0),
        .beat1       (w_beat1),
        .offset      (w_offset),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .data        (w_extract)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_req_err ? ST_RESP : ST_RD0;
                end
            end
            ST_RD0: begin
                if (mem_ready) begin
                    w_next = ST_CAP0;
                end
            end
            ST_CAP0: begin
`ifdef MISALIGNED_EN
                w_next = w_cross ? ST_RD1 : ST_RESP;
`else
                w_next = ST_RESP;
`endif
            end
`ifdef MISALIGNED_EN
            ST_RD1: begin
                if (mem_ready) begin
                    w_next = ST_CAP1;
                end
            end
            ST_CAP1: begin
                w_next = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (resp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = w_aligned;
        resp_valid    = 1'b0;
        resp_data     = '0;
        resp_err      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                req_ready = r_init & ~rst;
            end
            ST_RD0: begin
                mem_req_valid = 1'b1;
            end
`ifdef MISALIGNED_EN
            ST_RD1: begin
                mem_req_valid = 1'b1;
                mem_addr      = w_aligned + ADDR_WIDTH'(LANES);
            end
`endif
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_data  = r_err ? '0 : w_extract;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and beat capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_init     <= 1'b0;
            r_beat0    <= '0;
`ifdef MISALIGNED_EN
            r_beat1    <= '0;
`endif
        end else begin
            r_init <= 1'b1;
            if (w_accept) begin
                r_addr     <= req_addr;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_err      <= w_req_err;
`ifdef MISALIGNED_EN
                // A single-beat access must see zero in the upper beat.
                r_beat1    <= '0;
`endif
            end
            if (r_state == ST_CAP0) begin
                r_beat0 <= mem_rdata;
            end
`ifdef MISALIGNED_EN
            if (r_state == ST_CAP1) begin
                r_beat1 <= mem_rdata;
            end
`endif
        end
    end

endmodule : load_align_unit
`default_nettype wire

// File: tb/tb_load_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_align_unit
// Purpose  : Self-checking bench for load_align_unit (DATA_WIDTH=32).
//            A byte-array memory model derives every expected result and a
//            per-cycle schedule of handshakes; literal values pin key cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_align_unit;

`ifdef MISALIGNED_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        mem_req_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem_b [16];
    logic [31:0] mem_log [$];

    load_align_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .mem_req_valid (mem_req_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_err      (resp_err)
    );

    always #5 clk = ~clk;

    // 16-byte memory, aliased over the whole address space.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        int base;
        base = int'({a[3:2], 2'b00});
        return {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
    endfunction

    // Memory: data valid exactly one cycle after the accepting edge,
    // garbage otherwise.
    always @(posedge clk) begin : mem_model
        logic        hit;
        logic [31:0] a;
        hit = mem_req_valid && mem_ready;
        a   = mem_addr;
        if (hit) mem_log.push_back(a);
        #1 mem_rdata = hit ? word_at(a) : 32'hDEADBEEF;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    // Reference behaviour: result from byte-level reassembly, beat list.
    task automatic model(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         output logic err, output logic [31:0] data, output int nb,
                         output logic [31:0] a0);
        int   n;
        logic mis;
        n    = 1 << size;
        mis  = (addr % 32'(n)) != 0;
        err  = (size == 2'd3) || (mis && !MIS);
        data = '0;
        nb   = 0;
        a0   = addr & ~32'h3;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                data = data | (32'(mem_b[int'((addr + 32'(i)) % 32'd16)]) << (8 * i));
            end
            if (!uns && n < 4 && data[8*n-1]) data = data | (32'hFFFFFFFF << (8 * n));
            nb = (int'(addr % 32'd4) + n > 4) ? 2 : 1;
        end
    endtask

    task automatic run_req(input string name, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input int mstall, input int rstall,
                           output logic [31:0] got_data, output logic got_err);
        logic        exp_err;
        logic [31:0] exp_data;
        logic [31:0] a0;
        int          nb;
        int          k;
        int          rstart;
        int          last;
        bit          exp_mreq [64];
        logic [31:0] exp_maddr [64];

        model(addr, size, uns, exp_err, exp_data, nb, a0);
        for (int i = 0; i < 64; i++) begin
            exp_mreq[i]  = 1'b0;
            exp_maddr[i] = '0;
        end
        k = 1;
        for (int j = 0; j < nb; j++) begin
            for (int s = 0; s <= ((j == 0) ? mstall : 0); s++) begin
                exp_mreq[k]  = 1'b1;
                exp_maddr[k] = a0 + 32'(4 * j);
                k++;
            end
            k++;
        end
        rstart   = k;
        last     = rstart + rstall;
        got_data = 'x;
        got_err  = 1'bx;

        mem_log.delete();
        @(negedge clk);
        chk({name, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d req_ready", name, c), 32'(req_ready), 32'd0);
            chk($sformatf("%s c%0d mem_req_valid", name, c), 32'(mem_req_valid), 32'(exp_mreq[c]));
            if (exp_mreq[c])
                chk($sformatf("%s c%0d mem_addr", name, c), mem_addr, exp_maddr[c]);
            chk($sformatf("%s c%0d resp_valid", name, c), 32'(resp_valid), 32'(c >= rstart));
            if (c >= rstart) begin
                chk($sformatf("%s c%0d resp_data", name, c), resp_data, exp_data);
                chk($sformatf("%s c%0d resp_err", name, c), 32'(resp_err), 32'(exp_err));
                if (c == rstart) begin
                    got_data = resp_data;
                    got_err  = resp_err;
                end
            end
            mem_ready  = (c > mstall);
            resp_ready = (c >= last);
        end
        @(negedge clk);
        chk({name, " req_ready after"}, 32'(req_ready), 32'd1);
        chk({name, " resp_valid after"}, 32'(resp_valid), 32'd0);
        chk({name, " read count"}, 32'(mem_log.size()), 32'(nb));
        for (int j = 0; j < nb && j < mem_log.size(); j++)
            chk($sformatf("%s read%0d addr", name, j), mem_log[j], a0 + 32'(4 * j));
        mem_ready  = 1'b1;
        resp_ready = 1'b1;
    endtask

    initial begin : stim
        logic [31:0] d;
        logic        e;
        int          capk;

        for (int i = 0; i < 16; i++) mem_b[i] = 8'((i + 1) * 17);
        req_valid    = 1'b0;
        req_addr     = '0;
        req_size     = '0;
        req_unsigned = 1'b0;
        mem_ready    = 1'b1;
        resp_ready   = 1'b1;
        mem_rdata    = 32'hDEADBEEF;
        rst          = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_data", resp_data, 32'd0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst release req_ready", 32'(req_ready), 32'd1);

        run_req("sb7", 32'h7, 2'd0, 1'b0, 0, 0, d, e);
        chk("sb7 literal", d, 32'hFFFFFF88);
        chk("sb7 err literal", 32'(e), 32'd0);
        run_req("ub7", 32'h7, 2'd0, 1'b1, 0, 0, d, e);
        chk("ub7 literal", d, 32'h00000088);
        run_req("uh2", 32'h2, 2'd1, 1'b1, 0, 0, d, e);
        chk("uh2 literal", d, 32'h00004433);
        run_req("w2", 32'h2, 2'd2, 1'b0, 0, 0, d, e);
        chk("w2 literal", d, MIS ? 32'h66554433 : 32'h0);
        chk("w2 err literal", 32'(e), MIS ? 32'd0 : 32'd1);
        run_req("sz3", 32'h0, 2'd3, 1'b0, 0, 0, d, e);
        chk("sz3 err literal", 32'(e), 32'd1);
        run_req("sh3", 32'h3, 2'd1, 1'b0, 0, 0, d, e);
        chk("sh3 literal", d, MIS ? 32'h00005544 : 32'h0);
        run_req("bp", 32'h4, 2'd2, 1'b0, 3, 2, d, e);
        chk("bp literal", d, 32'h88776655);
        run_req("sh6", 32'h6, 2'd1, 1'b0, 0, 0, d, e);
        chk("sh6 literal", d, 32'hFFFF8877);
        run_req("sb1", 32'h1, 2'd0, 1'b0, 0, 0, d, e);
        chk("sb1 literal", d, 32'h00000022);
        run_req("wrap", 32'hFFFFFFFE, 2'd2, 1'b1, 0, 0, d, e);
        chk("wrap literal", d, MIS ? 32'h221110FF : 32'h0);
        run_req("bpx", 32'h5, 2'd2, 1'b0, 2, 1, d, e);
        chk("bpx literal", d, MIS ? 32'h99887766 : 32'h0);

        // Reset while the final capture state is active.
        capk = MIS ? 4 : 2;
        @(negedge clk);
        req_valid    = 1'b1;
        req_addr     = MIS ? 32'h2 : 32'h4;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (capk - 1) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst req_ready", 32'(req_ready), 32'd0);
        chk("midrst mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("midrst mem_addr", mem_addr, 32'd0);
        chk("midrst resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst resp_data", resp_data, 32'd0);
        chk("midrst resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        chk("midrst req_ready later", 32'(req_ready), 32'd1);

        run_req("post_rst", 32'h5, 2'd0, 1'b1, 0, 0, d, e);
        chk("post_rst literal", d, 32'h00000066);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_load_align_unit
`default_nettype wire

// File: doc/load_align_unit.md
# load_align_unit

Sequential load-alignment unit for the RV32I memory stage. It accepts a byte-addressed load request, issues one or two word-aligned reads to data memory, and returns a right-justified, sign- or zero-extended result. It generalises the combinational byte selector in three ways: the data width is parametrised, it has valid/ready handshakes on both sides, and it handles loads that cross a word boundary.

## Interface
- DATA_WIDTH, 32: memory word width in bits; must be 32 or 64. LANES = DATA_WIDTH/8.
- ADDR_WIDTH, 32: byte address width.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  access size is 2^req_size bytes: 0 byte, 1 half, 2 word, 3 dword. Size 3 is legal only when DATA_WIDTH=64.
- req_unsigned  in  1  1 selects zero extension, 0 selects sign extension.
- mem_req_valid  out  1  memory read request.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_addr  out  ADDR_WIDTH  word-aligned address (low log2(LANES) bits are zero).
- mem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after the accepting edge.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  DATA_WIDTH  aligned, extended data.
- resp_err  out  1  illegal size, or misaligned access when the feature is compiled out.

## Operation
- FSM states: IDLE, RD0, CAP0, RD1, CAP1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, size and unsigned.
  - If the size is illegal, or the access is misaligned with the feature compiled out, go to RESP with err=1, data=0, and issue no memory read.
  - Otherwise go to RD0.
- RD0 / RD1:
  - mem_req_valid=1.
  - mem_addr = aligned addr (RD0) or aligned addr + LANES, wrapping modulo 2^ADDR_WIDTH (RD1).
  - mem_addr is held stable until mem_ready; advance to CAP0 / CAP1 on mem_ready.
- CAP0 / CAP1:
  - Capture mem_rdata into beat0 / beat1.
  - CAP0 goes to RD1 if offset + 2^size > LANES (crossing); otherwise goes to RESP.
  - CAP1 goes to RESP.
- Extraction:
  - Form {beat1, beat0}; beat1 = 0 for a single-beat access.
  - Shift right by offset*8 and keep the low 8·2^size bits.
  - Extend to DATA_WIDTH: sign-extend from the top kept bit unless unsigned.
- RESP:
  - resp_valid=1; data and err are held until resp_ready, then return to IDLE.
  - No bypass: a new request is accepted one cycle after the handshake.
- req_ready=0 in every state except IDLE.

## Timing
- Reset values: req_ready=0 during reset and 1 the cycle after; mem_req_valid=0, mem_addr=0, resp_valid=0, resp_data=0, resp_err=0; state IDLE; beat registers 0.
- Latency from the accepting edge to resp_valid, with mem_ready=1: 3 cycles for a single beat, 5 cycles for a crossing access, 1 cycle for an error.
- Each cycle of mem_ready low adds one cycle of latency.
- Reset mid-operation: the FSM returns to IDLE and all outputs take their reset values. A memory read still in flight is discarded; the memory model must tolerate this.

## Configuration
- MISALIGNED_EN defined:
  - Accesses with a non-zero offset within the word are legal.
  - Crossing accesses take two beats.
- MISALIGNED_EN undefined:
  - Any access with addr mod 2^size ≠ 0 gets resp_err=1 and resp_data=0 after 1 cycle.
  - RD1 and CAP1 are not generated, and the beat1 register is removed.
  - Naturally aligned accesses behave identically in both builds.

## Structure
- Package load_align_pkg holds the state enum, the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD) and a function for the LANES-derived offset width.
- Sub-module byte_lane_extract: purely combinational shift, mask and extend, parametrised by DATA_WIDTH. The FSM and beat registers live in load_align_unit.

## Test plan
Memory model: word 0x0 = 0x44332211, word 0x4 = 0x88776655, DATA_WIDTH=32, mem_ready=1 and resp_ready=1 unless stated.
- Signed byte at 0x7 → resp_data=0xFFFFFF88, resp_err=0, resp_valid 3 cycles after the accept; unsigned gives 0x00000088.
- Unsigned half at 0x2 → 0x00004433, one mem_req at mem_addr 0x0.
- Word at 0x2:
  - MISALIGNED_EN defined: reads at 0x0 then 0x4, resp_data=0x66554433 after 5 cycles.
  - MISALIGNED_EN undefined: resp_err=1, resp_data=0 after 1 cycle, and mem_req_valid never asserted.
- req_size=3 on the 32-bit build → resp_err=1, no memory read. Signed half at 0x3 → 0x00005544 (crossing with the feature defined).
- Backpressure: mem_ready low for 3 cycles in RD0 and resp_ready low for 2 cycles in RESP → mem_addr and resp_data stay stable, req_ready stays 0, and the result is correct.
- Assert rst for 1 cycle while in CAP1 → all outputs 0 next cycle, req_ready=1 the cycle after, and the stale mem_rdata is ignored.
